div_req_arbiter: RTL and testbench
==================================

Name: div_req_arbiter

Overview:
- Shares one unsigned pipelined divider core (16-bit dividend/divisor in, 32-bit magnitude result out) between NREQ requesters.
- Arbitrates requests round-robin.
- Converts signed two's-complement operands to magnitudes, and tags each issued operation with requester ID, result sign and divide-by-zero flag in an in-order tag FIFO.
- Re-applies the sign to each core result and routes it back tagged with its requester ID.
- Sits between the eigenvalue datapath stages and the divider core instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_OUT, 8, maximum operations in flight in the core; tag FIFO depth (power of 2, ≥2).
- IDW, 2, width of the requester ID; must satisfy 2^IDW ≥ NREQ.

Ports:
- aclk  in  1  clock, all logic on the rising edge.
- aresetn  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid; must not depend on req_ready.
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready.
- req_dividend  in  NREQ*16  signed dividends; requester i uses bits [16i+15:16i].
- req_divisor  in  NREQ*16  signed divisors, packed the same way.
- core_dividend_tdata  out  16  unsigned dividend magnitude to the core.
- core_divisor_tdata  out  16  unsigned divisor magnitude to the core.
- core_tvalid  out  1  drives both core tvalid inputs.
- core_dout_tdata  in  32  unsigned result magnitude from the core.
- core_dout_tvalid  in  1  core result valid; no backpressure.
- rsp_valid  out  1  result valid, single-cycle pulse per result.
- rsp_id  out  IDW  requester that owns the result.
- rsp_data  out  32  signed result, two's complement.
- rsp_dbz  out  1  divisor was zero; rsp_data is forced to 0.
- busy  out  1  at least one operation in flight.
- err_underflow  out  1  sticky: core_dout_tvalid arrived with the tag FIFO empty.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - All outputs clear: req_ready, core_tvalid, core_*_tdata, rsp_valid, rsp_id, rsp_data, rsp_dbz, busy, err_underflow all 0.
  - Round-robin pointer = 0; tag FIFO emptied; outstanding count = 0.
  - Reset mid-operation discards all in-flight tags. Core results arriving after reset with the FIFO empty set err_underflow; the integrator must reset the core with the same aresetn.
- Credit:
  - can_issue = (outstanding < MAX_OUT), or (outstanding == MAX_OUT and core_dout_tvalid in the same cycle).
  - A simultaneous pop frees the slot in that cycle.
- Arbitration (combinational):
  - With can_issue=1, grant the first asserted req_valid searching from index ptr upward, wrapping modulo NREQ.
  - req_ready = one-hot grant, otherwise all 0. At most one grant per cycle.
- On transfer (edge E):
  - ptr ← granted index + 1, wrapping to 0.
  - Register magnitudes: |x| = x[15] ? (~x + 1) : x, taken as unsigned 16-bit. -32768 maps to 0x8000 with no saturation.
  - core_tvalid = 1 for exactly the cycle after E.
  - Push tag {id, neg = dividend[15]^divisor[15], dbz = (divisor == 0)}; outstanding += 1.
- No transfer at edge E → core_tvalid = 0 in the following cycle; data registers hold their values.
- On core_dout_tvalid (edge F):
  - Pop the tag; outstanding -= 1.
  - In the cycle after F: rsp_valid = 1, rsp_id = tag.id.
  - rsp_dbz = tag.dbz.
  - rsp_data = dbz ? 0 : (neg ? (~dout + 1) mod 2^32 : dout). Negating 0 yields 0.
- Simultaneous push and pop: FIFO pointers and outstanding count both update; count stays unchanged.
- core_dout_tvalid with the FIFO empty: result dropped, rsp_valid stays 0, err_underflow ← 1 (cleared only by reset).
- Results return in issue order; total latency from request transfer to rsp_valid = core latency + 2 cycles.
- busy = (outstanding != 0), registered.

Test Plan:
- Single request: req0 dividend 100, divisor 7 → req_ready[0]=1; next cycle core inputs 100/7, core_tvalid=1. Core model returns 0x000E_0000 → rsp_id=0, rsp_data=0x000E_0000, rsp_dbz=0.
- Signs: requester 2 sends -100/7 → core sees 100/7 and returns 0x000E_0000 → rsp_data=0xFFF2_0000. Requester 1 sends -8/-2 → rsp_data positive. Requester 3 sends -32768/1 → core_dividend_tdata=0x8000.
- Fairness: all 4 req_valid held high for 8 cycles, MAX_OUT=8 → grant order 0,1,2,3,0,1,2,3, then req_ready all 0 until the first result returns. Results come back with rsp_id in the same order.
- Credit boundary: 8 in flight while a pop and a new request occur in the same cycle → request granted; outstanding stays 8; busy stays 1.
- Divide by zero: requester 1 sends 5/0 → issued to the core; response has rsp_dbz=1, rsp_data=0, rsp_id=1. Neighbouring results are unaffected.
- Reset and underflow: aresetn low for 1 cycle with 3 ops in flight → outputs 0 and busy=0. The 3 stale core results then set err_underflow=1 and produce no rsp_valid.

Source files
------------

// File: rtl/div_req_arbiter.sv
// div_req_arbiter
//   Shares one unsigned pipelined divider core between NREQ signed requesters.
//   A round-robin arbiter picks one request per cycle. The arbiter sends the operand
//   magnitudes to the core and pushes a tag {id, neg, dbz} into an in-order FIFO.
//   When a core result returns, the arbiter pops the tag, re-applies the sign and
//   routes the result back tagged with the requester ID.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   req_valid/req_ready      per-requester handshake; req_ready is a one-hot grant
//   req_dividend/divisor     packed signed 16-bit operands, requester i at [16i+15:16i]
//   core_*_tdata/core_tvalid operand magnitudes to the divider core
//   core_dout_tdata/tvalid   unsigned 32-bit result from the core (no backpressure)
//   rsp_valid/id/data/dbz    signed result pulse back to the owning requester
//   busy                     at least one operation in flight
//   err_underflow            sticky: the core returned a result with no tag pending
module div_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned IDW     = 2
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_dividend,
  input  logic [NREQ*16-1:0] req_divisor,
  output logic [15:0]        core_dividend_tdata,
  output logic [15:0]        core_divisor_tdata,
  output logic               core_tvalid,
  input  logic [31:0]        core_dout_tdata,
  input  logic               core_dout_tvalid,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_data,
  output logic               rsp_dbz,
  output logic               busy,
  output logic               err_underflow
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = $clog2(MAX_OUT);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           neg;
    logic           dbz;
  } tag_t;

  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  tag_t           r_fifo [MAX_OUT];
  logic [15:0]    r_dvd;
  logic [15:0]    r_dvs;
  logic           r_core_valid;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [31:0]    r_rsp_data;
  logic           r_rsp_dbz;
  logic           r_busy;
  logic           r_err;

  logic           w_can_issue;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_idx;
  logic           w_xfer;
  logic           w_pop;
  logic [CW-1:0]  w_cnt_d;
  logic [15:0]    w_dvd;
  logic [15:0]    w_dvs;
  logic [IDW-1:0] w_ptr_d;
  tag_t           w_tag_in;
  tag_t           w_tag_out;
  logic [31:0]    w_rsp_data;

  function automatic logic [15:0] mag16(input logic [15:0] x);
    // -32768 maps to 0x8000, which the unsigned core reads as +32768
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  // A pop in the same cycle frees a slot, so a full pipe can still accept one
  assign w_can_issue = (r_cnt < CW'(MAX_OUT)) || ((r_cnt == CW'(MAX_OUT)) && core_dout_tvalid);

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_xfer    = 1'b0;
    if (w_can_issue) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_idx = IDW'((32'(r_ptr) + k) % NREQ);
        if (!w_xfer && req_valid[w_idx]) begin
          w_xfer    = 1'b1;
          w_gnt_idx = w_idx;
          w_gnt[w_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = w_gnt;

  assign w_dvd   = req_dividend[{w_gnt_idx, 4'b0000} +: 16];
  assign w_dvs   = req_divisor[{w_gnt_idx, 4'b0000} +: 16];
  assign w_ptr_d = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // A result with no tag pending is dropped and only flags underflow
  assign w_pop   = core_dout_tvalid && (r_cnt != '0);
  assign w_cnt_d = r_cnt + CW'(w_xfer) - CW'(w_pop);

  assign w_tag_in.id  = w_gnt_idx;
  assign w_tag_in.neg = w_dvd[15] ^ w_dvs[15];
  assign w_tag_in.dbz = (w_dvs == 16'd0);
  assign w_tag_out    = r_fifo[r_rd];

  always_comb begin
    w_rsp_data = core_dout_tdata;
    if (w_tag_out.dbz) begin
      w_rsp_data = 32'd0;
    end else if (w_tag_out.neg) begin
      w_rsp_data = ~core_dout_tdata + 32'd1;
    end
  end

  // Tag storage needs no reset: occupancy is tracked by r_cnt and the pointers
  always_ff @(posedge aclk) begin
    if (w_xfer) begin
      r_fifo[r_wr] <= w_tag_in;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_dvd        <= '0;
      r_dvs        <= '0;
      r_core_valid <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_dbz    <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_core_valid <= w_xfer;
      r_cnt        <= w_cnt_d;
      r_busy       <= (w_cnt_d != '0);
      r_rsp_valid  <= w_pop;
      if (w_xfer) begin
        r_ptr <= w_ptr_d;
        r_dvd <= mag16(w_dvd);
        r_dvs <= mag16(w_dvs);
        r_wr  <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd       <= r_rd + 1'b1;
        r_rsp_id   <= w_tag_out.id;
        r_rsp_dbz  <= w_tag_out.dbz;
        r_rsp_data <= w_rsp_data;
      end
      if (core_dout_tvalid && (r_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign core_dividend_tdata = r_dvd;
  assign core_divisor_tdata  = r_dvs;
  assign core_tvalid         = r_core_valid;
  assign rsp_valid           = r_rsp_valid;
  assign rsp_id              = r_rsp_id;
  assign rsp_data            = r_rsp_data;
  assign rsp_dbz             = r_rsp_dbz;
  assign busy                = r_busy;
  assign err_underflow       = r_err;

endmodule

// File: tb/tb_div_req_arbiter.sv
// tb_div_req_arbiter
//   Drives randomized and directed requests into div_req_arbiter. A pipelined
//   unsigned divider model sits behind it. A reference model predicts grants, core
//   operands, busy and underflow. It queues the expected signed responses, and a
//   monitor pops and compares them.
`timescale 1ns/1ps
module tb_div_req_arbiter;
  localparam int NREQ    = 4;
  localparam int MAX_OUT = 8;
  localparam int IDW     = 2;
  localparam int LAT     = 10;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_dividend;
  logic [NREQ*16-1:0] req_divisor;
  logic [15:0]        core_dividend_tdata;
  logic [15:0]        core_divisor_tdata;
  logic               core_tvalid;
  logic [31:0]        core_dout_tdata;
  logic               core_dout_tvalid;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_dbz;
  logic               busy;
  logic               err_underflow;

  div_req_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .IDW(IDW)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_dividend        (req_dividend),
    .req_divisor         (req_divisor),
    .core_dividend_tdata (core_dividend_tdata),
    .core_divisor_tdata  (core_divisor_tdata),
    .core_tvalid         (core_tvalid),
    .core_dout_tdata     (core_dout_tdata),
    .core_dout_tvalid    (core_dout_tvalid),
    .rsp_valid           (rsp_valid),
    .rsp_id              (rsp_id),
    .rsp_data            (rsp_data),
    .rsp_dbz             (rsp_dbz),
    .busy                (busy),
    .err_underflow       (err_underflow)
  );

  always #5 aclk = ~aclk;

  // Divider core model: fixed latency, quotient in the upper half, not reset
  logic [LAT-1:0] core_pv = '0;
  logic [31:0]    core_pd [LAT];
  always @(posedge aclk) begin
    core_pv <= {core_pv[LAT-2:0], (core_tvalid === 1'b1)};
    core_pd[0] <= (core_divisor_tdata == 16'd0) ? 32'hFFFF_FFFF :
                  {16'(core_dividend_tdata / core_divisor_tdata), 16'h0000};
    for (int i = 1; i < LAT; i++) core_pd[i] <= core_pd[i-1];
  end
  assign core_dout_tvalid = core_pv[LAT-1];
  assign core_dout_tdata  = core_pd[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        dbz;
  } exp_t;
  exp_t exp_q[$];

  int          m_out = 0;
  int          m_ptr = 0;
  bit          m_err = 1'b0;
  bit          pend_core = 1'b0;
  logic [15:0] pend_a, pend_b;
  bit          chk_en = 1'b0;
  bit          prev_rst = 1'b0;
  bit          auto_drop = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mag_model(input logic [15:0] x);
    longint s;
    s = longint'($signed(x));
    if (s < 0) s = -s;
    return s[15:0];
  endfunction

  // Expected signed response: sign(a/b) * (|a| / |b| scaled by 2^16), 0 on divide by zero
  function automatic logic [31:0] exp_data(input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return 32'h0;
    q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
    r = q * 65536;
    if ((sa < 0) != (sb < 0)) r = -r;
    return r[31:0];
  endfunction

  // Predictor: grant, core operands, busy and underflow; queues expected responses
  always @(negedge aclk) begin
    int          g;
    int          idx;
    bit          can;
    logic [NREQ-1:0] eg;
    logic [15:0] a, b;
    exp_t        e;
    if (chk_en) begin
      if (prev_rst) begin
        m_out = 0; m_ptr = 0; m_err = 1'b0; pend_core = 1'b0;
        exp_q.delete();
      end
      prev_rst = !aresetn;
      check("core_tvalid", {31'd0, core_tvalid}, {31'd0, pend_core});
      if (pend_core) begin
        check("core_dividend", {16'd0, core_dividend_tdata}, {16'd0, pend_a});
        check("core_divisor", {16'd0, core_divisor_tdata}, {16'd0, pend_b});
      end
      check("busy", {31'd0, busy}, {31'd0, (m_out != 0)});
      check("err_underflow", {31'd0, err_underflow}, {31'd0, m_err});
      can = (m_out < MAX_OUT) || (m_out == MAX_OUT && core_dout_tvalid);
      g = -1;
      if (can) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      check("req_ready", {28'd0, req_ready}, {28'd0, eg});
      pend_core = 1'b0;
      if (aresetn) begin
        if (core_dout_tvalid) begin
          if (m_out > 0) m_out--;
          else m_err = 1'b1;
        end
        if (g >= 0) begin
          a = req_dividend[16*g +: 16];
          b = req_divisor[16*g +: 16];
          e.id = g; e.data = exp_data(a, b); e.dbz = (b == 16'd0);
          exp_q.push_back(e);
          pend_a = mag_model(a); pend_b = mag_model(b); pend_core = 1'b1;
          m_ptr = (g + 1) % NREQ;
          m_out++;
        end
      end
    end
  end

  // Monitor: pops one expectation per response pulse
  always @(negedge aclk) begin
    exp_t e;
    if (chk_en && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d data=0x%08h, required no response",
                 rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", {30'd0, rsp_id}, e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, e.dbz});
      end
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i] = 1'b1;
    req_dividend[16*i +: 16] = a;
    req_divisor[16*i +: 16]  = b;
  endtask

  task automatic step();
    logic [NREQ-1:0] g;
    @(negedge aclk);
    g = req_valid & req_ready;
    @(posedge aclk);
    #1;
    if (auto_drop) req_valid = req_valid & ~g;
  endtask

  task automatic wait_drop();
    for (int c = 0; c < 100 && req_valid != '0; c++) step();
    check("grant_timeout", {28'd0, req_valid}, 32'd0);
    req_valid = '0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) step();
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h0001;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
    check({tag, "_core_tvalid"}, {31'd0, core_tvalid}, 32'd0);
    check({tag, "_core_dividend"}, {16'd0, core_dividend_tdata}, 32'd0);
    check({tag, "_core_divisor"}, {16'd0, core_divisor_tdata}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_id"}, {30'd0, rsp_id}, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_dbz"}, {31'd0, rsp_dbz}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err_underflow"}, {31'd0, err_underflow}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    repeat (LAT + 4) @(posedge aclk);
    #1;
    check_idle_outputs("reset");
    aresetn = 1'b1;
    chk_en = 1'b1;

    // Single request
    set_req(0, 16'd100, 16'd7);
    wait_drop();
    drain();

    // Signed operands, including the most negative dividend
    set_req(2, 16'(-100), 16'd7);
    set_req(1, 16'(-8), 16'(-2));
    set_req(3, 16'h8000, 16'd1);
    wait_drop();
    drain();

    // Fairness and credit boundary: everyone requests continuously
    auto_drop = 1'b0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, rnd16(), rnd16());
      step();
    end
    req_valid = '0;
    auto_drop = 1'b1;
    drain();

    // Divide by zero between ordinary neighbours
    set_req(0, 16'd1000, 16'(-3));
    set_req(1, 16'd5, 16'd0);
    set_req(2, 16'(-7), 16'd2);
    wait_drop();
    drain();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rnd16(), rnd16());
      end
      step();
    end
    wait_drop();
    drain();

    // Reset with three operations in flight, then stale core results
    set_req(0, 16'd50, 16'd5);
    set_req(1, 16'd60, 16'd6);
    set_req(2, 16'd70, 16'd7);
    wait_drop();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    check_idle_outputs("midreset");
    repeat (LAT + 6) step();
    check("err_underflow_sticky", {31'd0, err_underflow}, 32'd1);
    check("rsp_after_reset", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
